adex_tdm_scheduler: RTL and testbench

Time-division scheduler that shares one AdEx neuron update core among `N_NEURONS` virtual neurons. It holds each neuron's V/w state in a register file and paces timesteps from a programmable tick. On each timestep it issues one start/done transaction per neuron to the shared core and writes the results back. It collects a per-timestep spike vector and sits between the core and the top-level output mux.

---
 rtl/adex_tdm_scheduler_if.sv | 26 ++
 rtl/adex_tdm_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_adex_tdm_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adex_tdm_scheduler_if.sv
// Handshake and operand/result bus between the TDM scheduler and the
// shared AdEx neuron update core.
interface adex_tdm_scheduler_if #(
    parameter int IDX_W = 2
);
    logic                   core_start;
    logic [IDX_W-1:0]       core_idx;
    logic signed [11:0]     core_v_out;
    logic signed [11:0]     core_w_out;
    logic                   core_done;
    logic signed [11:0]     core_v_in;
    logic signed [11:0]     core_w_in;
    logic                   core_spike;

    // Scheduler side: issues operands, receives results.
    modport master (
        output core_start, core_idx, core_v_out, core_w_out,
        input  core_done, core_v_in, core_w_in, core_spike
    );

    // Core side: receives operands, returns results.
    modport slave (
        input  core_start, core_idx, core_v_out, core_w_out,
        output core_done, core_v_in, core_w_in, core_spike
    );
endinterface

// File: rtl/adex_tdm_scheduler.sv
// Time-division scheduler sharing one AdEx update core among N_NEURONS
// virtual neurons. Holds per-neuron V/w, paces timesteps from a
// programmable tick, runs one start/done transaction per neuron and
// collects the spike vector of each completed timestep. V/w values pass
// through bit-exact; any saturation belongs to the core.
module adex_tdm_scheduler #(
    parameter int                 N_NEURONS    = 4,
    parameter int                 IDX_W        = 2,
    parameter logic signed [11:0] V_INIT       = 12'shBF0,
    parameter logic signed [11:0] W_INIT       = 12'sh000,
    parameter int                 CORE_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               tick_period,
    input  logic                     clear_state,
    adex_tdm_scheduler_if.master     core_bus,
    output logic [N_NEURONS-1:0]     spike_vec,
    output logic                     step_valid,
    output logic [15:0]              step_count,
    output logic                     overrun,
    output logic                     timeout_err,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [11:0]       rd_v,
    output logic signed [11:0]       rd_w
);

    localparam int                TMO_W    = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(CORE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [7:0]              tick_cnt_q;
    logic                    tick;

    logic [IDX_W-1:0]        idx_q;
    logic [TMO_W-1:0]        tmo_q;
    logic signed [11:0]      cap_v_q;
    logic signed [11:0]      cap_w_q;
    logic                    cap_spike_q;
    logic [N_NEURONS-1:0]    acc_q;
    logic [N_NEURONS-1:0]    acc_set;

    logic signed [11:0]      v_mem [N_NEURONS];
    logic signed [11:0]      w_mem [N_NEURONS];

    logic                    start_step;
    logic                    do_clear;
    logic                    done_hit;
    logic                    tmo_hit;
    logic                    last_idx;

    // ------------------------------------------------------------------
    // Tick generation: a tick fires on the cycle the counter matches
    // tick_period; the counter is parked at 0 while disabled.
    // ------------------------------------------------------------------
    assign tick = enable && (tick_cnt_q == tick_period);

    // Tick counter: runs while enabled, wraps on a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= 8'd0;
        end else if (!enable || tick) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every always_ff samples pre-edge values regardless of order.
            tick_cnt_q <= 8'd0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shared decode terms
    // ------------------------------------------------------------------
    // A clear in IDLE swallows a coincident tick without flagging overrun.
    assign do_clear   = (state_q == ST_IDLE) && clear_state;
    assign start_step = (state_q == ST_IDLE) && tick && !clear_state;
    // core_done on the expiry cycle wins over the timeout.
    assign done_hit   = (state_q == ST_WAIT) && core_bus.core_done;
    assign tmo_hit    = (state_q == ST_WAIT) && !core_bus.core_done && (tmo_q == TMO_LAST);
    assign last_idx   = (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_step)           state_d = ST_ISSUE;
            ST_ISSUE:                           state_d = ST_WAIT;
            ST_WAIT:  if (done_hit || tmo_hit)  state_d = ST_WRITE;
            ST_WRITE: state_d = last_idx ? ST_DONE : ST_ISSUE;
            ST_DONE:                            state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Accumulator as it will stand once the current WRITE has landed;
    // used to publish the final spike vector in the same edge.
    always_comb begin
        acc_set        = acc_q;
        acc_set[idx_q] = cap_spike_q;
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    // Per-neuron sequencing, result capture, spike accumulation and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            tmo_q       <= '0;
            cap_v_q     <= '0;
            cap_w_q     <= '0;
            cap_spike_q <= 1'b0;
            acc_q       <= '0;
            spike_vec   <= '0;
            step_count  <= 16'd0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // A tick that finds the scheduler busy is dropped and flagged.
            if (tick && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_step) begin
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    tmo_q <= '0;
                end
                ST_WAIT: begin
                    if (done_hit) begin
                        cap_v_q     <= core_bus.core_v_in;
                        cap_w_q     <= core_bus.core_w_in;
                        cap_spike_q <= core_bus.core_spike;
                    end else if (tmo_hit) begin
                        // Abandon this neuron: write back its old state, no spike.
                        cap_v_q     <= v_mem[idx_q];
                        cap_w_q     <= w_mem[idx_q];
                        cap_spike_q <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_WRITE: begin
                    acc_q <= acc_set;
                    if (last_idx) begin
                        spike_vec  <= acc_set;
                        step_count <= step_count + 16'd1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: reset/clear to the init values, write-back in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this small register file is part of the architectural
            // state and must come out of reset at V_INIT/W_INIT, so unlike a
            // RAM it is reset explicitly.
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= W_INIT;
            end
        end else if (do_clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= W_INIT;
            end
        end else if (state_q == ST_WRITE) begin
            v_mem[idx_q] <= cap_v_q;
            w_mem[idx_q] <= cap_w_q;
        end
    end

    // Observation read port; out-of-range indices read the init values.
    always_comb begin
        rd_v = V_INIT;
        rd_w = W_INIT;
        if (int'(rd_idx) < N_NEURONS) begin
            rd_v = v_mem[rd_idx];
            rd_w = w_mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Core-facing outputs: operands track idx and the register file, and
    // stay stable from ISSUE through WRITE because nothing writes entry
    // idx before then.
    // ------------------------------------------------------------------
    assign core_bus.core_start = (state_q == ST_ISSUE);
    assign core_bus.core_idx   = idx_q;
    assign core_bus.core_v_out = v_mem[idx_q];
    assign core_bus.core_w_out = w_mem[idx_q];

    assign step_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_adex_tdm_scheduler.sv
// Randomised scoreboard bench for adex_tdm_scheduler. A reference model
// decides, per clock, whether a tick is accepted, dropped or swallowed by a
// clear, computes the whole timestep at once and queues the expected result;
// a separate monitor pops and compares whenever step_valid is seen.
module tb_adex_tdm_scheduler;
    localparam int          N      = 4;
    localparam int          IW     = 2;
    localparam logic [11:0] V_INIT = 12'hBF0;
    localparam logic [11:0] W_INIT = 12'h000;
    localparam int          TMO    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    tick_period;
    logic          clear_state;
    logic [N-1:0]  spike_vec;
    logic          step_valid;
    logic [15:0]   step_count;
    logic          overrun;
    logic          timeout_err;
    logic [IW-1:0] rd_idx;
    logic [11:0]   rd_v;
    logic [11:0]   rd_w;

    adex_tdm_scheduler_if #(.IDX_W(IW)) core_bus ();

    adex_tdm_scheduler #(
        .N_NEURONS(N), .IDX_W(IW), .V_INIT(V_INIT), .W_INIT(W_INIT), .CORE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick_period(tick_period),
        .clear_state(clear_state), .core_bus(core_bus), .spike_vec(spike_vec),
        .step_valid(step_valid), .step_count(step_count), .overrun(overrun),
        .timeout_err(timeout_err), .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- core behaviour (shared by core model and reference)
    int          mode;      // 0: V=0x100+idx, w=idx, spike on odd idx; 1: salted
    logic [11:0] salt;
    int          lat_l;     // cycles from core_start to core_done
    int          dead_idx;  // neuron the core never answers (-1: none)

    function automatic logic [24:0] core_fn(input int idx, input logic [11:0] v, input logic [11:0] w);
        logic [11:0] nv, nw;
        logic        sp;
        if (mode == 0) begin
            nv = 12'h100 + 12'(idx);
            nw = 12'(idx);
            sp = idx[0];
        end else begin
            nv = v + salt + 12'(idx * 37);
            nw = w ^ (salt + 12'(idx));
            sp = salt[idx];
        end
        return {sp, nv, nw};
    endfunction

    // ---------------- reference model
    typedef struct packed {
        int                  cyc;
        logic [N-1:0]        spk;
        logic [15:0]         cnt;
        logic [N-1:0][11:0]  v;
        logic [N-1:0][11:0]  w;
    } step_t;

    step_t              exp_q[$];
    logic [N-1:0][11:0] mv, mw;
    logic [15:0]        m_count;
    logic               ov_exp, tmo_exp;
    int                 busy_done;
    int                 run_len;
    int                 cyc = 0;
    logic               sweep_req = 1'b0;

    always @(posedge clk) begin : ref_model
        step_t rec;
        int    t;
        logic  tick_now, idle;
        logic [24:0] r;
        cyc++;
        if (reset) begin
            for (int i = 0; i < N; i++) begin mv[i] = V_INIT; mw[i] = W_INIT; end
            m_count = 16'd0; ov_exp = 1'b0; tmo_exp = 1'b0;
            busy_done = -100; run_len = 0;
            exp_q.delete();
        end else begin
            run_len  = enable ? run_len + 1 : 0;
            tick_now = enable && ((run_len % (int'(tick_period) + 1)) == 0);
            idle     = (cyc >= busy_done + 2);
            if (idle && clear_state) begin
                for (int i = 0; i < N; i++) begin mv[i] = V_INIT; mw[i] = W_INIT; end
            end else if (tick_now) begin
                if (idle) begin
                    t = 0;
                    rec.spk = '0;
                    for (int i = 0; i < N; i++) begin
                        if (i == dead_idx) begin
                            t += TMO + 2;
                            tmo_exp = 1'b1;
                        end else begin
                            r = core_fn(i, mv[i], mw[i]);
                            mv[i] = r[23:12];
                            mw[i] = r[11:0];
                            rec.spk[i] = r[24];
                            t += lat_l + 2;
                        end
                    end
                    m_count  = m_count + 16'd1;
                    rec.cyc  = cyc + t;
                    rec.cnt  = m_count;
                    rec.v    = mv;
                    rec.w    = mw;
                    busy_done = rec.cyc;
                    exp_q.push_back(rec);
                end else begin
                    ov_exp = 1'b1;
                end
            end
        end
    end

    // ---------------- core model
    initial begin : core_model
        logic [24:0] r;
        core_bus.core_done  = 1'b0;
        core_bus.core_v_in  = 12'($urandom);
        core_bus.core_w_in  = 12'($urandom);
        core_bus.core_spike = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && core_bus.core_start && int'(core_bus.core_idx) != dead_idx) begin
                r = core_fn(int'(core_bus.core_idx), core_bus.core_v_out, core_bus.core_w_out);
                repeat (lat_l) @(posedge clk);
                #1;
                core_bus.core_done  = 1'b1;
                core_bus.core_v_in  = r[23:12];
                core_bus.core_w_in  = r[11:0];
                core_bus.core_spike = r[24];
                @(posedge clk);
                #1;
                core_bus.core_done  = 1'b0;
                core_bus.core_v_in  = 12'($urandom);
                core_bus.core_w_in  = 12'($urandom);
                core_bus.core_spike = 1'($urandom);
            end
        end
    end

    // ---------------- start-order checker: idx runs 0..N-1 within a step
    initial begin : idx_checker
        int n_start;
        n_start = 0;
        forever begin
            @(negedge clk);
            if (reset) n_start = 0;
            else if (core_bus.core_start) begin
                check("core_idx", 32'(core_bus.core_idx), 32'(n_start));
                n_start = (n_start + 1) % N;
            end
        end
    end

    // ---------------- monitor
    task automatic sweep(input logic [N-1:0][11:0] ev, input logic [N-1:0][11:0] ew, input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = IW'(i);
            #1;
            check($sformatf("%s rd_v[%0d]", tag, i), 32'(rd_v), 32'(ev[i]));
            check($sformatf("%s rd_w[%0d]", tag, i), 32'(rd_w), 32'(ew[i]));
        end
    endtask

    initial begin : monitor
        step_t rec;
        rd_idx = '0;
        forever begin
            @(negedge clk);
            if (!reset && step_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_step: step_valid at cycle %0d, none queued", cyc);
                end else begin
                    rec = exp_q.pop_front();
                    check("step_cycle", 32'(cyc), 32'(rec.cyc));
                    check("spike_vec", 32'(spike_vec), 32'(rec.spk));
                    check("step_count", 32'(step_count), 32'(rec.cnt));
                    sweep(rec.v, rec.w, "step");
                end
            end else if (sweep_req) begin
                sweep(mv, mw, "snapshot");
                sweep_req = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick_once(input logic clr);
        @(posedge clk); #1;
        tick_period = 8'd0;
        enable      = 1'b1;
        clear_state = clr;
        @(posedge clk); #1;
        enable      = 1'b0;
        clear_state = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cyc < busy_done + 2) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: timestep still pending after %0d cycles", budget);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic request_sweep();
        int n;
        sweep_req = 1'b1;
        n = 0;
        while (sweep_req && n < 20) begin @(negedge clk); n++; end
        if (sweep_req) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep_wait: snapshot not taken within 20 cycles");
            sweep_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence
    initial begin : main
        int n;
        reset = 1'b1; enable = 1'b0; clear_state = 1'b0; tick_period = 8'd0;
        mode = 0; salt = 12'h000; lat_l = 1; dead_idx = -1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst core_start", 32'(core_bus.core_start), 32'd0);
        check("rst step_valid", 32'(step_valid), 32'd0);
        check("rst step_count", 32'(step_count), 32'd0);
        check("rst spike_vec", 32'(spike_vec), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        request_sweep();
        @(posedge clk); #1;
        reset = 1'b0;

        // Single timestep, L=1, fixed core results
        tick_once(1'b0);
        wait_idle(200);
        check("t1 spike_vec", 32'(spike_vec), 32'b1010);
        check("t1 step_count", 32'(step_count), 32'd1);

        // L=20 with a tick every 10 cycles: overrun and dropped ticks
        @(posedge clk); #1;
        lat_l = 20; mode = 1; salt = 12'($urandom); tick_period = 8'd9; enable = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_idle(400);
        check("t2 overrun", 32'(overrun), 32'd1);
        check("t2 overrun model", 32'(overrun), 32'(ov_exp));

        // done on the timeout-expiry cycle counts as done
        lat_l = TMO;
        tick_once(1'b0);
        wait_idle(1000);
        check("t3 expiry timeout_err", 32'(timeout_err), 32'd0);

        // core never answers idx 2
        lat_l = 3; dead_idx = 2; salt = 12'hFFF;
        tick_once(1'b0);
        wait_idle(1000);
        check("t3 timeout_err", 32'(timeout_err), 32'd1);
        check("t3 spike_vec", 32'(spike_vec), 32'b1011);
        dead_idx = -1;

        // clear and tick in the same IDLE cycle
        do_reset();
        lat_l = 2; salt = 12'($urandom);
        tick_once(1'b0);
        wait_idle(200);
        tick_once(1'b1);
        repeat (40) @(negedge clk);
        wait_idle(200);
        request_sweep();
        check("t4 step_count", 32'(step_count), 32'd1);
        check("t4 overrun", 32'(overrun), 32'd0);

        // clear while busy is ignored
        tick_once(1'b0);
        repeat (4) @(posedge clk);
        #1; clear_state = 1'b1;
        @(posedge clk); #1; clear_state = 1'b0;
        wait_idle(200);
        request_sweep();

        // reset during WAIT of idx 1
        lat_l = 10;
        tick_once(1'b0);
        n = 0;
        while (!(core_bus.core_start && core_bus.core_idx == IW'(1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5 reached idx1", 32'(n < 100), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5 core_start", 32'(core_bus.core_start), 32'd0);
        check("t5 step_count", 32'(step_count), 32'd0);
        check("t5 step_valid", 32'(step_valid), 32'd0);
        @(posedge clk); #1;
        request_sweep();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        lat_l = 1;
        tick_once(1'b0);
        wait_idle(200);
        check("t5 step_count", 32'(step_count), 32'd1);

        // randomised segments
        for (int s = 0; s < 12; s++) begin
            @(posedge clk); #1;
            tick_period = 8'($urandom_range(0, 40));
            lat_l       = $urandom_range(1, 8);
            mode        = 1;
            salt        = 12'($urandom);
            dead_idx    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
            n = $urandom_range(30, 250);
            repeat (n) begin
                @(posedge clk); #1;
                enable      = ($urandom_range(0, 9) != 0);
                clear_state = ($urandom_range(0, 15) == 0);
            end
            enable = 1'b0;
            clear_state = 1'b0;
            wait_idle(2000);
            check($sformatf("rand%0d overrun", s), 32'(overrun), 32'(ov_exp));
            check($sformatf("rand%0d timeout_err", s), 32'(timeout_err), 32'(tmo_exp));
            check($sformatf("rand%0d step_count", s), 32'(step_count), 32'(m_count));
        end
        request_sweep();

        check("pending_steps", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin : watchdog
        #500_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
